// File: rtl/rd_unpacker_pkg.sv
// Shared types and default widths for the FIFO read-side word unpacker.
package rd_unpacker_pkg;

   // Holding-register occupancy: IDLE = nothing held, ACTIVE = word held.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int C_DEF_IN_WIDTH  = 32;
   localparam int C_DEF_OUT_WIDTH = 8;
   localparam int C_DEF_LSB_FIRST = 1;

endpackage : rd_unpacker_pkg

// File: rtl/rd_unpacker.sv
// Pops words from a show-ahead FIFO and streams each one out as R equal
// slices with valid/ready handshaking. The pop for the next word is issued
// on the last slice's transfer so back-to-back words stream without a bubble.
module rd_unpacker
   import rd_unpacker_pkg::*;
#(
   parameter int C_IN_WIDTH  = C_DEF_IN_WIDTH,
   parameter int C_OUT_WIDTH = C_DEF_OUT_WIDTH,
   parameter int C_LSB_FIRST = C_DEF_LSB_FIRST
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_fifo_empty,
   input  logic [C_IN_WIDTH-1:0]  i_fifo_data,
   output logic                   o_fifo_ren,
   output logic                   o_valid,
   output logic [C_OUT_WIDTH-1:0] o_data,
   output logic                   o_last,
   input  logic                   i_ready,
   output logic                   o_busy
);

   // Slices per word and slice-index width (at least one bit so R=1 still works).
   localparam int R     = C_IN_WIDTH / C_OUT_WIDTH;
   localparam int IDX_W = (R > 1) ? $clog2(R) : 1;

   // Reject width combinations that do not split into a power-of-two slice count.
   generate
      if ((C_OUT_WIDTH < 1) || (R < 1) || ((C_IN_WIDTH % C_OUT_WIDTH) != 0) ||
          ((R & (R - 1)) != 0)) begin : g_bad_ratio
         $error("rd_unpacker: C_IN_WIDTH/C_OUT_WIDTH must be an integer power of two");
      end
   endgenerate

   state_t                  r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [C_IN_WIDTH-1:0]   r_hold;

   logic                    w_active;
   logic                    w_last_idx;
   logic                    w_transfer;
   logic                    w_load;
   logic [IDX_W-1:0]        w_sel;

   assign w_active   = (r_state == ACTIVE);
   assign w_last_idx = (r_idx == IDX_W'(R - 1));
   assign w_transfer = w_active & i_ready;

   // Pop when empty-handed, or when the final slice leaves this cycle. Gated by
   // reset so nothing is popped while the block is being held in reset.
   assign w_load = i_rst_n & ~i_fifo_empty & (~w_active | (w_transfer & w_last_idx));

   assign o_fifo_ren = w_load;
   assign o_valid    = w_active;
   assign o_busy     = w_active;
   assign o_last     = w_active & w_last_idx;

   // Slice order: index counts up; MSB-first mode mirrors it.
   assign w_sel = (C_LSB_FIRST != 0) ? r_idx : (IDX_W'(R - 1) - r_idx);

   // Inline slice multiplexer over the holding register.
   always_comb begin
      o_data = '0;
      for (int k = 0; k < R; k++) begin
         if (w_sel == IDX_W'(k)) begin
            o_data = r_hold[k*C_OUT_WIDTH +: C_OUT_WIDTH];
         end
      end
   end

   // Occupancy FSM, slice index and holding register: load wins over drain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_hold  <= '0;
      end else if (w_load) begin
         r_state <= ACTIVE;
         r_idx   <= '0;
         r_hold  <= i_fifo_data;
      end else if (w_transfer) begin
         if (w_last_idx) begin
            r_state <= IDLE;
            r_idx   <= '0;
         end else begin
            r_idx   <= r_idx + 1'b1;
         end
      end
   end

endmodule : rd_unpacker

// File: tb/tb_rd_unpacker.sv
// Directed bench for rd_unpacker: LSB-first, MSB-first and R=1 instances,
// each fed by a small show-ahead FIFO model.
module tb_rd_unpacker;

   logic clk;
   logic rst_n;

   int total;
   int bad;

   // ---------------- instance A: 32 -> 8, LSB first ----------------
   logic [31:0] a_mem [0:15];
   logic [4:0]  a_wr, a_rd;
   logic        a_empty, a_ren, a_valid, a_last, a_ready, a_busy;
   logic [31:0] a_fdata;
   logic [7:0]  a_dout;

   assign a_empty = (a_wr == a_rd);
   assign a_fdata = a_mem[a_rd[3:0]];
   always @(posedge clk) if (a_ren) a_rd <= a_rd + 5'd1;

   rd_unpacker #(.C_IN_WIDTH(32), .C_OUT_WIDTH(8), .C_LSB_FIRST(1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(a_empty), .i_fifo_data(a_fdata),
      .o_fifo_ren(a_ren), .o_valid(a_valid), .o_data(a_dout), .o_last(a_last),
      .i_ready(a_ready), .o_busy(a_busy));

   // ---------------- instance B: 32 -> 8, MSB first ----------------
   logic [31:0] b_mem [0:15];
   logic [4:0]  b_wr, b_rd;
   logic        b_empty, b_ren, b_valid, b_last, b_ready, b_busy;
   logic [31:0] b_fdata;
   logic [7:0]  b_dout;

   assign b_empty = (b_wr == b_rd);
   assign b_fdata = b_mem[b_rd[3:0]];
   always @(posedge clk) if (b_ren) b_rd <= b_rd + 5'd1;

   rd_unpacker #(.C_IN_WIDTH(32), .C_OUT_WIDTH(8), .C_LSB_FIRST(0)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(b_empty), .i_fifo_data(b_fdata),
      .o_fifo_ren(b_ren), .o_valid(b_valid), .o_data(b_dout), .o_last(b_last),
      .i_ready(b_ready), .o_busy(b_busy));

   // ---------------- instance C: 32 -> 32 (R=1) ----------------
   logic [31:0] c_mem [0:15];
   logic [4:0]  c_wr, c_rd;
   logic        c_empty, c_ren, c_valid, c_last, c_ready, c_busy;
   logic [31:0] c_fdata;
   logic [31:0] c_dout;

   assign c_empty = (c_wr == c_rd);
   assign c_fdata = c_mem[c_rd[3:0]];
   always @(posedge clk) if (c_ren) c_rd <= c_rd + 5'd1;

   rd_unpacker #(.C_IN_WIDTH(32), .C_OUT_WIDTH(32), .C_LSB_FIRST(1)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(c_empty), .i_fifo_data(c_fdata),
      .o_fifo_ren(c_ren), .o_valid(c_valid), .o_data(c_dout), .o_last(c_last),
      .i_ready(c_ready), .o_busy(c_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_a(input logic [31:0] w);
      a_mem[a_wr[3:0]] = w;
      a_wr = a_wr + 5'd1;
   endtask

   task automatic push_b(input logic [31:0] w);
      b_mem[b_wr[3:0]] = w;
      b_wr = b_wr + 5'd1;
   endtask

   task automatic push_c(input logic [31:0] w);
      c_mem[c_wr[3:0]] = w;
      c_wr = c_wr + 5'd1;
   endtask

   // Reset holds every output low and suppresses the pop even with data waiting.
   task automatic test_reset();
      @(negedge clk);
      push_a(32'hAABBCCDD);
      #1;
      total++; if (a_ren !== 1'b0) begin bad++; $display("FAIL reset_ren got=%b want=0", a_ren); end
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", a_valid); end
      total++; if (a_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", a_last); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", a_dout); end
      total++; if (b_valid !== 1'b0 || c_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_bc got=%b%b want=00", b_valid, c_valid); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Word queued during reset streams LSB first with a single pop.
   task automatic test_lsb_first();
      logic [7:0] exp [0:3];
      int         rens;
      exp[0] = 8'hDD; exp[1] = 8'hCC; exp[2] = 8'hBB; exp[3] = 8'hAA;
      rens = 0;
      #1;
      total++; if (a_ren !== 1'b1 || a_valid !== 1'b0) begin bad++; $display("FAIL lsb_load ren=%b valid=%b want ren=1 valid=0", a_ren, a_valid); end
      if (a_ren === 1'b1) rens++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         total++; if (a_valid !== 1'b1 || a_dout !== exp[i]) begin bad++; $display("FAIL lsb_slice%0d valid=%b data=%h want 1/%h", i, a_valid, a_dout, exp[i]); end
         total++; if (a_last !== (i == 3)) begin bad++; $display("FAIL lsb_last%0d got=%b want=%b", i, a_last, (i == 3)); end
         if (a_ren === 1'b1) rens++;
      end
      @(negedge clk); #1;
      total++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL lsb_idle valid=%b busy=%b want 0/0", a_valid, a_busy); end
      total++; if (rens != 1) begin bad++; $display("FAIL lsb_pops got=%0d want=1", rens); end
   endtask

   // Same word through the MSB-first instance.
   task automatic test_msb_first();
      logic [7:0] exp [0:3];
      exp[0] = 8'hAA; exp[1] = 8'hBB; exp[2] = 8'hCC; exp[3] = 8'hDD;
      push_b(32'hAABBCCDD);
      #1;
      total++; if (b_ren !== 1'b1) begin bad++; $display("FAIL msb_load ren=%b want=1", b_ren); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         total++; if (b_valid !== 1'b1 || b_dout !== exp[i] || b_last !== (i == 3)) begin
            bad++; $display("FAIL msb_slice%0d valid=%b data=%h last=%b want 1/%h/%b", i, b_valid, b_dout, b_last, exp[i], (i == 3));
         end
      end
      @(negedge clk); #1;
      total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL msb_idle valid=%b want=0", b_valid); end
   endtask

   // Stall on slice 1 for three cycles; the slice must hold, then resume.
   task automatic test_backpressure();
      push_a(32'hAABBCCDD);
      #1;
      total++; if (a_ren !== 1'b1) begin bad++; $display("FAIL bp_load ren=%b want=1", a_ren); end
      @(negedge clk); #1;
      total++; if (a_dout !== 8'hDD) begin bad++; $display("FAIL bp_slice0 got=%h want=dd", a_dout); end
      @(negedge clk);
      a_ready = 1'b0;
      #1;
      total++; if (a_valid !== 1'b1 || a_dout !== 8'hCC) begin bad++; $display("FAIL bp_stall0 valid=%b data=%h want 1/cc", a_valid, a_dout); end
      for (int i = 1; i < 3; i++) begin
         @(negedge clk); #1;
         total++; if (a_valid !== 1'b1 || a_dout !== 8'hCC || a_last !== 1'b0 || a_ren !== 1'b0) begin
            bad++; $display("FAIL bp_stall%0d valid=%b data=%h last=%b ren=%b want 1/cc/0/0", i, a_valid, a_dout, a_last, a_ren);
         end
      end
      @(negedge clk);
      a_ready = 1'b1;
      #1;
      total++; if (a_dout !== 8'hCC) begin bad++; $display("FAIL bp_release got=%h want=cc", a_dout); end
      @(negedge clk); #1;
      total++; if (a_dout !== 8'hBB || a_last !== 1'b0) begin bad++; $display("FAIL bp_resume data=%h last=%b want bb/0", a_dout, a_last); end
      @(negedge clk); #1;
      total++; if (a_dout !== 8'hAA || a_last !== 1'b1) begin bad++; $display("FAIL bp_final data=%h last=%b want aa/1", a_dout, a_last); end
      @(negedge clk); #1;
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL bp_idle valid=%b want=0", a_valid); end
   endtask

   // Two preloaded words: 8 contiguous slices, pops at cycle 0 and cycle 4.
   task automatic test_back_to_back();
      logic [7:0] exp [1:8];
      exp[1] = 8'h44; exp[2] = 8'h33; exp[3] = 8'h22; exp[4] = 8'h11;
      exp[5] = 8'h88; exp[6] = 8'h77; exp[7] = 8'h66; exp[8] = 8'h55;
      push_a(32'h11223344);
      push_a(32'h55667788);
      #1;
      total++; if (a_ren !== 1'b1 || a_valid !== 1'b0) begin bad++; $display("FAIL b2b_c0 ren=%b valid=%b want 1/0", a_ren, a_valid); end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk); #1;
         total++; if (a_valid !== 1'b1 || a_dout !== exp[i]) begin bad++; $display("FAIL b2b_c%0d valid=%b data=%h want 1/%h", i, a_valid, a_dout, exp[i]); end
         total++; if (a_ren !== (i == 4) || a_last !== (i == 4 || i == 8)) begin
            bad++; $display("FAIL b2b_ctl%0d ren=%b last=%b want %b/%b", i, a_ren, a_last, (i == 4), (i == 4 || i == 8));
         end
      end
      @(negedge clk); #1;
      total++; if (a_valid !== 1'b0 || a_ren !== 1'b0) begin bad++; $display("FAIL b2b_idle valid=%b ren=%b want 0/0", a_valid, a_ren); end
   endtask

   // Reset mid-word drops the rest of the word; next FIFO word starts at slice 0.
   task automatic test_reset_mid_word();
      logic [7:0] exp [0:3];
      exp[0] = 8'h04; exp[1] = 8'h03; exp[2] = 8'h02; exp[3] = 8'h01;
      push_a(32'hAABBCCDD);
      push_a(32'h01020304);
      @(negedge clk); #1;
      total++; if (a_dout !== 8'hDD) begin bad++; $display("FAIL rmw_slice0 got=%h want=dd", a_dout); end
      @(negedge clk); #1;
      total++; if (a_dout !== 8'hCC) begin bad++; $display("FAIL rmw_slice1 got=%h want=cc", a_dout); end
      rst_n = 1'b0;
      #1;
      total++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_dout !== 8'h00 || a_ren !== 1'b0) begin
         bad++; $display("FAIL rmw_async valid=%b busy=%b data=%h ren=%b want 0/0/00/0", a_valid, a_busy, a_dout, a_ren);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (a_ren !== 1'b1 || a_valid !== 1'b0) begin bad++; $display("FAIL rmw_reload ren=%b valid=%b want 1/0", a_ren, a_valid); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         total++; if (a_valid !== 1'b1 || a_dout !== exp[i] || a_last !== (i == 3)) begin
            bad++; $display("FAIL rmw_next%0d valid=%b data=%h last=%b want 1/%h/%b", i, a_valid, a_dout, a_last, exp[i], (i == 3));
         end
      end
      @(negedge clk); #1;
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rmw_idle valid=%b want=0", a_valid); end
   endtask

   // R=1 stage with random ready: each word once, in order, last==valid.
   task automatic test_r1();
      logic [31:0] exp [0:2];
      int          got;
      logic        ren_exp;
      exp[0] = 32'hDEADBEEF; exp[1] = 32'h12345678; exp[2] = 32'hCAFEF00D;
      got = 0;
      push_c(exp[0]); push_c(exp[1]); push_c(exp[2]);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         c_ready = (cyc < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         ren_exp = ~c_empty & (~c_valid | c_ready);
         total++; if (c_last !== c_valid) begin bad++; $display("FAIL r1_last cyc%0d last=%b valid=%b", cyc, c_last, c_valid); end
         total++; if (c_ren !== ren_exp) begin bad++; $display("FAIL r1_ren cyc%0d got=%b want=%b", cyc, c_ren, ren_exp); end
         if (c_valid === 1'b1 && c_ready === 1'b1) begin
            total++;
            if (got > 2) begin
               bad++; $display("FAIL r1_extra cyc%0d data=%h want no word", cyc, c_dout);
            end else if (c_dout !== exp[got]) begin
               bad++; $display("FAIL r1_word%0d got=%h want=%h", got, c_dout, exp[got]);
            end
            got++;
         end
      end
      total++; if (got != 3) begin bad++; $display("FAIL r1_count got=%0d want=3", got); end
      total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL r1_idle valid=%b want=0", c_valid); end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0;
      a_wr = '0; a_rd = '0; b_wr = '0; b_rd = '0; c_wr = '0; c_rd = '0;
      a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_word();
      test_r1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rd_unpacker

// File: doc/rd_unpacker.md
RD_UNPACKER -- requirements
Module: rd_unpacker

Interface
REQ-001 SHALL have parameter C_IN_WIDTH, default 32: FIFO word width; SHALL equal C_WIDTH of the feeding FIFO.
REQ-002 SHALL have parameter C_OUT_WIDTH, default 8: output slice width; C_IN_WIDTH/C_OUT_WIDTH (R) SHALL be an integer power of two, >=1.
REQ-003 SHALL have parameter C_LSB_FIRST, default 1: 1 emits the least-significant slice first, 0 the most-significant slice first.
REQ-004 SHALL have port i_clk  input  1  sole clock; the same clock as the FIFO read side.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port i_fifo_data  input  C_IN_WIDTH  show-ahead FIFO head word, valid whenever i_fifo_empty=0.
REQ-008 SHALL have port o_fifo_ren  output  1  pop strobe to the FIFO.
REQ-009 SHALL have port o_valid  output  1  slice valid.
REQ-010 SHALL have port o_data  output  C_OUT_WIDTH  current slice.
REQ-011 SHALL have port o_last  output  1  current slice is the final slice of its word.
REQ-012 SHALL have port i_ready  input  1  downstream accepts the slice.
REQ-013 SHALL have port o_busy  output  1  a word is held, i.e. the block is in state ACTIVE.

Function
REQ-014 SHALL hold one C_IN_WIDTH word in a holding register and track it with a state machine: IDLE (no word held) and ACTIVE (word held).
REQ-015 SHALL keep a slice index of width max(1,log2 R), counting 0..R-1.
REQ-016 SHALL define transfer = o_valid & i_ready; o_valid SHALL equal (state==ACTIVE).
REQ-017 SHALL define the load condition: o_fifo_ren = !i_fifo_empty & (state==IDLE | (transfer & index==R-1)); o_fifo_ren SHALL be combinational and SHALL never assert while i_fifo_empty=1.
REQ-018 On every cycle with o_fifo_ren=1, SHALL capture i_fifo_data into the holding register, clear the index to 0 and enter or remain in ACTIVE.
REQ-019 On a transfer with index<R-1, SHALL increment the index.
REQ-020 On a transfer with index==R-1 and no load, SHALL enter IDLE and clear the index to 0.
REQ-021 SHALL select o_data as slice number index when C_LSB_FIRST=1, and as slice number R-1-index otherwise.
REQ-022 o_last SHALL equal o_valid & (index==R-1).
REQ-023 While o_valid=1 and i_ready=0, SHALL hold o_data, o_last and the index stable.
REQ-024 Latency: a word whose i_fifo_empty falls in cycle n while the block is IDLE SHALL appear with o_valid=1 in cycle n+1.
REQ-025 Throughput: with i_ready held high and the FIFO non-empty, SHALL produce one slice per cycle with no bubble between words (back-to-back refill on the last slice).
REQ-026 When R=1, SHALL act as a one-entry registered stage: o_last SHALL equal o_valid, and a pop SHALL occur on every transfer while the FIFO is non-empty.
REQ-027 If the FIFO goes empty mid-word, SHALL finish the held word normally and then idle with o_valid=0.

Reset
REQ-028 While i_rst_n=0, SHALL hold state IDLE, index 0 and the holding register at 0.
REQ-029 While i_rst_n=0, SHALL drive o_valid=0, o_last=0, o_busy=0, o_data=0 and o_fifo_ren=0 (o_fifo_ren gated by reset).
REQ-030 An assertion of reset during a word SHALL discard the unsent slices; that word SHALL NOT be re-read.
REQ-031 SHALL let the first load occur no earlier than the first rising edge after i_rst_n deasserts.

Structure
REQ-032 SHALL place in shared package rd_unpacker_pkg: the state enum (IDLE, ACTIVE) and the default width constants.
REQ-033 SHALL compute R and the index width as local constants inside the module.
REQ-034 SHALL contain no sub-module; the slice multiplexer SHALL be inline logic.
REQ-035 SHALL check the power-of-two constraint on R with an elaboration-time assertion.

Verification
REQ-036 Scenario, LSB-first: FIFO holds 0xAABBCCDD, i_ready=1 -> o_data 0xDD,0xCC,0xBB,0xAA on 4 consecutive cycles, o_last only on 0xAA, exactly one o_fifo_ren pulse.
REQ-037 Scenario, C_LSB_FIRST=0 with the same word -> o_data order 0xAA,0xBB,0xCC,0xDD.
REQ-038 Scenario, backpressure: i_ready=0 for 3 cycles on slice 1 -> o_data stays 0xCC and the index is unchanged; the stream resumes with 0xBB.
REQ-039 Scenario, back-to-back: two words preloaded, i_ready=1 -> 8 contiguous valid cycles, o_fifo_ren high at cycle 0 and cycle 4 only.
REQ-040 Scenario, reset mid-word: i_rst_n driven low after slice 1 -> o_valid=0 asynchronously; after release the next FIFO word streams from slice 0.
REQ-041 Scenario, R=1 (C_OUT_WIDTH=32): 3 words with random i_ready -> each word emitted once, in order, o_last=o_valid, no pop while i_fifo_empty=1.
